// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Command/response bus between two masters and the mem_arbiter.
//   Lane i of each packed field belongs to master i.
//
//   Handshake: a command on lane i transfers in a cycle where m_valid[i] and
//   m_ready[i] are both high. m_ready[i] never rises without m_valid[i], and
//   a master keeps m_wr/m_addr/m_wdata stable while valid is high and ready
//   is low, because the arbiter does not latch unaccepted commands. Read
//   responses have no back-pressure: m_rvalid[i] is a one-cycle strobe that
//   qualifies the shared m_rdata.
//
//   m_valid  : master -> arbiter, per-master command present
//   m_wr     : master -> arbiter, 1 = write, 0 = read
//   m_addr   : master -> arbiter, lane i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   m_wdata  : master -> arbiter, lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_ready  : arbiter -> master, command accepted this cycle
//   m_rvalid : arbiter -> master, read data strobe for master i
//   m_rdata  : arbiter -> master, read data shared by both masters
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
);
  logic [1:0]              m_valid;
  logic [1:0]              m_wr;
  logic [2*ADDR_WIDTH-1:0] m_addr;
  logic [2*DATA_WIDTH-1:0] m_wdata;
  logic [1:0]              m_ready;
  logic [1:0]              m_rvalid;
  logic [DATA_WIDTH-1:0]   m_rdata;

  modport master (
    output m_valid, m_wr, m_addr, m_wdata,
    input  m_ready, m_rvalid, m_rdata
  );

  modport slave (
    input  m_valid, m_wr, m_addr, m_wdata,
    output m_ready, m_rvalid, m_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-master round-robin arbiter and sequencer in front of a single-port
//   memory. One command is accepted per cycle, registered onto the memory
//   strobes for one cycle, and tracked through a two-stage {read, owner}
//   pipeline so read data comes back to the issuing master two cycles after
//   its handshake.
//
//   clk    : clock, rising edge
//   reset  : synchronous, active-low
//   bus    : mem_arbiter_if.slave, master command/response bus
//   addr   : memory address (registered)
//   wr_en  : memory write enable (registered)
//   rd_en  : memory read enable (registered)
//   wdata  : memory write data (registered)
//   rdata  : memory read data, valid the cycle after rd_en is sampled
//   busy   : handshake this cycle, command in issue stage, or read pending
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_arbiter_if.slave          bus,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy
);

  // Round-robin pointer: master that wins the next tie.
  logic                  prio_q, prio_d;

  // Issue stage: drives the memory directly; owner rides alongside.
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  wr_en_q, wr_en_d;
  logic                  rd_en_q, rd_en_d;
  logic                  iss_id_q, iss_id_d;

  // Response stage: aligned with the memory's rdata.
  logic                  rsp_rd_q, rsp_rd_d;
  logic                  rsp_id_q, rsp_id_d;

  logic [1:0]            grant;
  logic                  sel;
  logic                  accept;

  always_comb begin
    grant    = 2'b00;
    prio_d   = prio_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wr_en_d  = 1'b0;
    rd_en_d  = 1'b0;
    iss_id_d = iss_id_q;

    // No grants while reset is asserted, so nothing enters the pipeline.
    if (reset) begin
      if (bus.m_valid[0] && (!bus.m_valid[1] || !prio_q)) begin
        grant[0] = 1'b1;
      end else if (bus.m_valid[1]) begin
        grant[1] = 1'b1;
      end
    end

    accept = |grant;
    sel    = grant[1];

    if (accept) begin
      prio_d   = ~sel;
      addr_d   = bus.m_addr[(sel ? ADDR_WIDTH : 0) +: ADDR_WIDTH];
      wdata_d  = bus.m_wdata[(sel ? DATA_WIDTH : 0) +: DATA_WIDTH];
      wr_en_d  = bus.m_wr[sel];
      rd_en_d  = ~bus.m_wr[sel];
      iss_id_d = sel;
    end

    // Writes need no response, so only the read flag advances.
    rsp_rd_d = rd_en_q;
    rsp_id_d = iss_id_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      prio_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wr_en_q  <= 1'b0;
      rd_en_q  <= 1'b0;
      iss_id_q <= 1'b0;
      rsp_rd_q <= 1'b0;
      rsp_id_q <= 1'b0;
    end else begin
      prio_q   <= prio_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wr_en_q  <= wr_en_d;
      rd_en_q  <= rd_en_d;
      iss_id_q <= iss_id_d;
      rsp_rd_q <= rsp_rd_d;
      rsp_id_q <= rsp_id_d;
    end
  end

  assign bus.m_ready  = grant;
  assign bus.m_rvalid = {rsp_rd_q & rsp_id_q, rsp_rd_q & ~rsp_id_q};
  // Zero outside a response so the shared data bus is quiet when idle.
  assign bus.m_rdata  = rsp_rd_q ? rdata : '0;

  assign addr  = addr_q;
  assign wdata = wdata_q;
  assign wr_en = wr_en_q;
  assign rd_en = rd_en_q;
  assign busy  = accept | wr_en_q | rd_en_q | rsp_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int AW = 2;
  localparam int DW = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  logic [AW-1:0] addr;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata = '0;
  logic          busy;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .addr  (addr),
    .wr_en (wr_en),
    .rd_en (rd_en),
    .wdata (wdata),
    .rdata (rdata),
    .busy  (busy)
  );

  // Behavioural single-port memory: rdata valid the cycle after rd_en.
  logic [DW-1:0] mem [4] = '{8'h00, 8'h11, 8'h22, 8'h33};
  always @(posedge clk) begin
    if (wr_en === 1'b1) mem[addr] <= wdata;
    if (rd_en === 1'b1) rdata <= mem[addr];
  end

  // ---------------- check bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- vectors / driver ----------------
  typedef struct {
    logic          rst_n;
    logic [1:0]    valid;
    logic [1:0]    wr;
    logic [AW-1:0] a0;
    logic [AW-1:0] a1;
    logic [DW-1:0] d0;
    logic [DW-1:0] d1;
    logic [1:0]    exp_ready;
  } vec_t;

  vec_t vecs[$];
  logic tb_prio = 1'b0;

  task automatic add_vec(input logic rst_n, input logic [1:0] valid, input logic [1:0] wr,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                         input logic [1:0] exp_ready);
    vec_t v;
    v.rst_n = rst_n; v.valid = valid; v.wr = wr; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.exp_ready = exp_ready;
    vecs.push_back(v);
  endtask

  // Drives one cycle, checks the combinational ready, advances to next cycle.
  task automatic run_vec(input vec_t v, input string name);
    reset         = v.rst_n;
    bus.m_valid   = v.valid;
    bus.m_wr      = v.wr;
    bus.m_addr    = {v.a1, v.a0};
    bus.m_wdata   = {v.d1, v.d0};
    @(negedge clk);
    check(name, {30'd0, bus.m_ready}, {30'd0, v.exp_ready});
    if (!v.rst_n)            tb_prio = 1'b0;
    else if (v.exp_ready[0]) tb_prio = 1'b1;
    else if (v.exp_ready[1]) tb_prio = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [DW:0]   exp_q[$];   // {owner, data}
  int            due_q[$];   // cycle each response is due
  logic [DW-1:0] shadow [4] = '{8'h00, 8'h11, 8'h22, 8'h33};
  logic [AW-1:0] e_addr  = '0;
  logic [DW-1:0] e_wdata = '0;
  logic          e_wr    = 1'b0;
  logic          e_rd    = 1'b0;
  logic          rst_prev = 1'b1;
  logic          armed    = 1'b0;
  int            cyc      = 0;

  always @(negedge clk) begin : monitor
    logic [1:0]    hs;
    logic [1:0]    e_rv;
    logic [DW-1:0] e_rdata;
    logic          due;
    logic          g;
    logic [AW-1:0] a;
    logic [DW:0]   ent;
    cyc++;
    if (rst_prev === 1'b0) begin
      armed = 1'b1;
      exp_q.delete();
      due_q.delete();
      e_addr = '0; e_wdata = '0; e_wr = 1'b0; e_rd = 1'b0;
    end
    if (armed) begin
      e_rv = 2'b00; e_rdata = '0; due = 1'b0;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        ent = exp_q.pop_front();
        void'(due_q.pop_front());
        due = 1'b1;
        e_rv = ent[DW] ? 2'b10 : 2'b01;
        e_rdata = ent[DW-1:0];
      end
      hs = (reset === 1'b1) ? (bus.m_valid & bus.m_ready) : 2'b00;
      check($sformatf("wr_en c%0d", cyc), {31'd0, wr_en}, {31'd0, e_wr});
      check($sformatf("rd_en c%0d", cyc), {31'd0, rd_en}, {31'd0, e_rd});
      check($sformatf("addr c%0d", cyc), {30'd0, addr}, {30'd0, e_addr});
      check($sformatf("wdata c%0d", cyc), {24'd0, wdata}, {24'd0, e_wdata});
      check($sformatf("m_rvalid c%0d", cyc), {30'd0, bus.m_rvalid}, {30'd0, e_rv});
      if (due || rst_prev === 1'b0)
        check($sformatf("m_rdata c%0d", cyc), {24'd0, bus.m_rdata}, {24'd0, e_rdata});
      check($sformatf("busy c%0d", cyc), {31'd0, busy},
            {31'd0, (|hs) | e_wr | e_rd | due});
      // Record this cycle's acceptance as next cycle's expected issue.
      if (hs != 2'b00) begin
        g = ~hs[0];
        a = g ? bus.m_addr[AW +: AW] : bus.m_addr[0 +: AW];
        e_addr  = a;
        e_wdata = g ? bus.m_wdata[DW +: DW] : bus.m_wdata[0 +: DW];
        e_wr    = bus.m_wr[g];
        e_rd    = ~bus.m_wr[g];
        if (bus.m_wr[g]) begin
          shadow[a] = e_wdata;
        end else begin
          exp_q.push_back({g, shadow[a]});
          due_q.push_back(cyc + 2);
        end
      end else begin
        e_wr = 1'b0;
        e_rd = 1'b0;
      end
    end
    rst_prev = reset;
  end

  // ---------------- stimulus ----------------
  initial begin : main
    vec_t v;
    // reset held with both masters valid
    add_vec(0, 2'b11, 2'b00, 2'd1, 2'd3, 8'h00, 8'h00, 2'b00);
    add_vec(0, 2'b11, 2'b00, 2'd1, 2'd3, 8'h00, 8'h00, 2'b00);
    // single master: write 0xA5 to 2, then read 2
    add_vec(1, 2'b01, 2'b01, 2'd2, 2'd0, 8'hA5, 8'h00, 2'b01);
    add_vec(1, 2'b01, 2'b00, 2'd2, 2'd0, 8'h00, 8'h00, 2'b01);
    add_vec(1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00);
    // m1 alone, then contention: carry-over gives m0 first, then alternate
    add_vec(1, 2'b10, 2'b00, 2'd0, 2'd3, 8'h00, 8'h00, 2'b10);
    for (int i = 0; i < 6; i++)
      add_vec(1, 2'b11, 2'b00, 2'd1, 2'd3, 8'h00, 8'h00, (i % 2 == 0) ? 2'b01 : 2'b10);
    add_vec(1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00);
    add_vec(1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00);
    // m1 read, then reset mid-flight; first tie after release goes to m0
    add_vec(1, 2'b10, 2'b00, 2'd0, 2'd2, 8'h00, 8'h00, 2'b10);
    add_vec(0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00);
    add_vec(1, 2'b11, 2'b00, 2'd1, 2'd3, 8'h00, 8'h00, 2'b01);
    add_vec(1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00);
    // m0 read leaves prio at 1, reset clears it back to 0
    add_vec(1, 2'b01, 2'b00, 2'd3, 2'd0, 8'h00, 8'h00, 2'b01);
    add_vec(0, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00);
    add_vec(1, 2'b11, 2'b00, 2'd1, 2'd3, 8'h00, 8'h00, 2'b01);
    add_vec(1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00);
    // m0 writes 0x5C to 0, m1 reads 0 next cycle
    add_vec(1, 2'b01, 2'b01, 2'd0, 2'd0, 8'h5C, 8'h00, 2'b01);
    add_vec(1, 2'b10, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b10);
    for (int i = 0; i < 3; i++)
      add_vec(1, 2'b00, 2'b00, 2'd0, 2'd0, 8'h00, 8'h00, 2'b00);

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("m_ready vec%0d", i));

    // random traffic; expected grant from the round-robin rule
    for (int i = 0; i < 60; i++) begin
      v.rst_n = 1'b1;
      v.valid = 2'($urandom_range(0, 3));
      v.wr    = 2'($urandom_range(0, 3));
      v.a0    = AW'($urandom_range(0, 3));
      v.a1    = AW'($urandom_range(0, 3));
      v.d0    = DW'($urandom_range(0, 255));
      v.d1    = DW'($urandom_range(0, 255));
      case (v.valid)
        2'b01:   v.exp_ready = 2'b01;
        2'b10:   v.exp_ready = 2'b10;
        2'b11:   v.exp_ready = tb_prio ? 2'b10 : 2'b01;
        default: v.exp_ready = 2'b00;
      endcase
      run_vec(v, $sformatf("m_ready rnd%0d", i));
    end

    v.rst_n = 1'b1; v.valid = 2'b00; v.wr = 2'b00; v.a0 = '0; v.a1 = '0;
    v.d0 = '0; v.d1 = '0; v.exp_ready = 2'b00;
    for (int i = 0; i < 4; i++) run_vec(v, "m_ready drain");
    check("responses outstanding", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester round-robin arbiter and sequencer in front of the single-port `memory` block. It accepts read/write commands from two independent masters over a valid/ready handshake and drives the memory's `addr`/`rd_en`/`wr_en`/`wdata` from registers. It routes each read's `rdata` back to the master that issued the read, tagged with a per-master response strobe.

## Interface

Parameters:
- `ADDR_WIDTH`, default 2: memory address width.
- `DATA_WIDTH`, default 8: memory data width.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `reset` input 1: synchronous, active-low reset, sampled on `clk`.
- `m_valid` input 2: bit i means master i presents a command.
- `m_wr` input 2: bit i = 1 for a write, 0 for a read, for master i.
- `m_addr` input 2*ADDR_WIDTH: master i's address in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `m_wdata` input 2*DATA_WIDTH: master i's write data in bits [i*DATA_WIDTH +: DATA_WIDTH].
- `m_ready` output 2: bit i means master i's command is accepted this cycle. Combinational from `m_valid` and the priority register.
- `m_rvalid` output 2: one-cycle pulse on bit i when the read data for master i is on `m_rdata`.
- `m_rdata` output DATA_WIDTH: read data, shared by both masters; qualify with `m_rvalid`.
- `addr` output ADDR_WIDTH: memory address, registered.
- `wr_en` output 1: memory write enable, registered.
- `rd_en` output 1: memory read enable, registered.
- `wdata` output DATA_WIDTH: memory write data, registered.
- `rdata` input DATA_WIDTH: memory read data, valid on the cycle after `rd_en` is sampled.
- `busy` output 1: high while any accepted command is still in the issue or response pipeline.

## Operation

- A handshake completes in a cycle where `m_valid[i]` and `m_ready[i]` are both high. At most one master is granted per cycle, and the arbiter grants every cycle without bubbles.
- Arbitration:
  - If exactly one master is valid, it is granted.
  - If both are valid, the master indicated by priority register `prio` is granted.
  - After any grant to master i, `prio` becomes 1-i.
  - `m_ready[i]` is 0 whenever `m_valid[i]` is 0.
- Issue stage: on acceptance, the selected command is registered onto `addr`/`wdata`/`wr_en`/`rd_en` for exactly one cycle.
  - A write drives `wr_en` = 1, `rd_en` = 0. A read drives `rd_en` = 1, `wr_en` = 0.
  - With no acceptance, `wr_en` = `rd_en` = 0 and `addr`/`wdata` hold their previous values.
- Response tracking: a 2-deep shift pipeline carries {read flag, owner id} alongside each issued command.
  - When a read reaches the response stage, `m_rvalid[owner]` pulses and `m_rdata` = `rdata`.
  - Writes produce no response.
- Ordering: commands execute in acceptance order. A write accepted in cycle N followed by a read of the same address accepted in N+1 returns the new data.
- `busy` = any `m_valid & m_ready` this cycle, OR an issue-stage command present, OR a response-stage read pending.
- Reset (`reset` = 0 at a rising edge) puts the block in this state on the next cycle:
  - `addr` = 0, `wdata` = 0, `wr_en` = 0, `rd_en` = 0.
  - `m_rvalid` = 0, `m_rdata` = 0, `busy` = 0, `prio` = 0 (master 0 wins the first tie).
  - Pipeline flushed: reads in flight at reset never produce `m_rvalid`.
  - `m_ready` = 0 while `reset` is low.

## Timing

- Command accepted in cycle N: memory strobes are visible in cycle N+1 and sampled by the memory at the end of N+1.
- Read response: `m_rvalid`/`m_rdata` are registered and valid in cycle N+2. Read latency from handshake is 2 cycles.
- Throughput is one command per cycle. Back-to-back reads accepted in N and N+1 respond in N+2 and N+3 respectively.
- Simultaneous valid on both masters every cycle gives a strict alternating grant sequence.
- A master's command fields must stay stable while `m_valid` is high and `m_ready` is low. The arbiter does not latch unaccepted commands.

## Test plan

- Reset: hold `reset` = 0 for 2 cycles with both `m_valid` high. Required: all memory strobes 0, `m_ready` = 00, `m_rvalid` = 00, `busy` = 0.
- Single master: master 0 writes 0xA5 to address 2, then reads address 2 in the next cycle. Required: `wr_en` = 1 with `addr` = 2 and `wdata` = 0xA5 one cycle after the write handshake; `m_rvalid` = 01 with `m_rdata` = 0xA5 exactly two cycles after the read handshake.
- Contention: both masters hold valid reads continuously for 6 cycles (m0 reads address 1, m1 reads address 3; memory preloaded with 0x11 and 0x33). Required: grants alternate 0,1,0,1,0,1 starting with 0; responses alternate `m_rvalid` 01/10 with data 0x11/0x33.
- Priority carry-over: master 1 alone is granted, then both become valid. Required: master 0 is granted next.
- Reset mid-flight: master 1 read accepted in cycle N and `reset` = 0 in cycle N+1. Required: no `m_rvalid` pulse in N+2 or later; after reset release, the first tie goes to master 0.
- Write-read ordering across masters: m0 writes 0x5C to address 0 in cycle N and m1 reads address 0 in cycle N+1. Required: `m_rvalid` = 10 with `m_rdata` = 0x5C in N+3.
